// File: rtl/sto_ncb_pkg.sv
// Shared definitions for the per-CB store stage: state encodings, widths and
// the Ncb-to-word-count helper.
package sto_ncb_pkg;

  localparam int BUF_AW = 12;
  localparam int DATA_W = 64;
  // One bit wider than the 12-bit byte-to-word quotient so that the round-up
  // of a 32767-byte Ncb (4096 words) does not wrap to zero.
  localparam int NCB8_W = 13;

  typedef logic [DATA_W-1:0] sto_data_t;
  typedef logic [BUF_AW-1:0] buf_addr_t;
  typedef logic [NCB8_W-1:0] ncb_words_t;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_INI       = 4'd1;
  localparam logic [3:0] ST_CFG       = 4'd2;
  localparam logic [3:0] ST_WAIT_COMB = 4'd3;
  localparam logic [3:0] ST_WAIT_CMD  = 4'd4;
  localparam logic [3:0] ST_CMD       = 4'd5;
  localparam logic [3:0] ST_DATA      = 4'd6;
  localparam logic [3:0] ST_END       = 4'd7;
  localparam logic [3:0] ST_END_ALL   = 4'd8;
  localparam logic [3:0] ST_ERR       = 4'd9;

  function automatic ncb_words_t ncb_words(input logic [14:0] ncb_size);
    return {1'b0, ncb_size[14:3]} + {{(NCB8_W-1){1'b0}}, |ncb_size[2:0]};
  endfunction

endpackage

// File: rtl/sto_ncb_rd_skid.sv
// Small FIFO absorbing local-buffer read data so reads can run ahead of write
// FIFO back-pressure without dropping or duplicating words.
module sto_ncb_rd_skid
  import sto_ncb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_mem_clk,
  input  logic          i_rst_n,
  input  logic          flush,
  input  logic          push,
  input  sto_data_t     push_data,
  input  logic          pop,
  output sto_data_t     head,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  sto_data_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && !empty;

  always_ff @(posedge i_mem_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/sto_ncb.sv
// Per-CB store stage: drains each combined Ncb from the ping-pong buffer half
// into HARQ memory over the local write bus and reports per-half completion.
//
// state      | meaning
// IDLE       | waiting for a job start with a non-zero CB count
// INI        | latch HARQ base address, clear done/error, ptr to half 0
// CFG        | latch Ncb word count; zero length is an error
// WAIT_COMB  | wait until the half at o_sto_ptr has been combined
// WAIT_CMD   | wait for the write channel to accept a new command
// CMD        | one-cycle command strobe, reset read/push counters
// DATA       | stream buffer words through the skid into the write FIFO
// END        | per-half done pulse, flip ptr, advance CB count and address
// END_ALL    | raise the held job-done level
// ERR        | one-cycle abort: flag error, terminate bus, flush skid
module sto_ncb
  import sto_ncb_pkg::*;
#(
  parameter int STO_SWIDTH = 4,
  parameter int SKID_DEPTH = 2
) (
  input  logic        i_mem_clk,
  input  logic        i_rst_n,
  input  logic        i_harq_start,
  input  logic        i_harq_end,
  input  logic [4:0]  i_cb_num,
  input  logic [14:0] i_ncb_size,
  input  logic [31:0] i_tb_harq_baddr,
  input  logic        i_comb0_done,
  input  logic        i_comb1_done,
  output logic        o_sto0_done,
  output logic        o_sto1_done,
  output logic        o_sto_ncb_done,
  output logic        o_sto_ptr,
  output logic        o_sto_ren,
  output logic [11:0] o_sto_addr,
  input  logic [63:0] i_sto_rdata,
  output logic        o_wr_cmd_strb,
  input  logic        i_wr_cmd_done,
  output logic [15:0] o_wr_data_number,
  output logic [31:0] o_wr_baddr,
  output logic        o_wr,
  output logic [63:0] o_wdata,
  input  logic        i_wfull,
  output logic        o_wr_termi,
  output logic        o_sto_err
);

  localparam int SKID_CW = $clog2(SKID_DEPTH + 1);

  logic [STO_SWIDTH-1:0] state;
  logic [STO_SWIDTH-1:0] state_nxt;
  logic [4:0]            cb_num_r;
  logic [4:0]            cb_cnt;
  ncb_words_t            ncb_8_r;
  ncb_words_t            rd_issued;
  ncb_words_t            wr_pushed;
  logic [31:0]           baddr_r;
  buf_addr_t             addr_r;
  logic                  ptr_r;
  logic                  comb0_rdy;
  logic                  comb1_rdy;
  logic                  ren_q;
  logic                  err_r;
  logic                  ncb_done_r;
  logic                  sto0_done_r;
  logic                  sto1_done_r;

  sto_data_t             skid_head;
  logic [SKID_CW-1:0]    skid_cnt;
  logic                  skid_empty;
  logic                  skid_flush;
  logic [SKID_CW:0]      skid_occ;

  logic                  half_rdy;
  logic                  ren;
  logic                  wr_push;
  logic                  last_push;
  logic                  do_end;

  assign half_rdy  = ptr_r ? comb1_rdy : comb0_rdy;
  // A read already in flight owns a skid slot even though its data has not landed.
  assign skid_occ  = {1'b0, skid_cnt} + {{SKID_CW{1'b0}}, ren_q};
  assign ren       = (state == ST_DATA) && (rd_issued < ncb_8_r)
                     && (skid_occ < (SKID_CW + 1)'(SKID_DEPTH));
  assign wr_push   = (state == ST_DATA) && !skid_empty && !i_wfull;
  assign last_push = wr_push && (wr_pushed == ncb_8_r - 1'b1);
  assign do_end    = (state == ST_END) && (state_nxt != ST_ERR);
  assign skid_flush = (state == ST_ERR) || (state == ST_INI);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (i_harq_start && (i_cb_num != 5'd0)) state_nxt = ST_INI;
      ST_INI:       state_nxt = ST_CFG;
      ST_CFG:       state_nxt = (ncb_words(i_ncb_size) == '0) ? ST_ERR : ST_WAIT_COMB;
      ST_WAIT_COMB: if (half_rdy) state_nxt = ST_WAIT_CMD;
      ST_WAIT_CMD:  if (i_wr_cmd_done) state_nxt = ST_CMD;
      ST_CMD:       state_nxt = ST_DATA;
      ST_DATA:      if (last_push) state_nxt = ST_END;
      ST_END:       state_nxt = (cb_cnt != cb_num_r - 5'd1) ? ST_WAIT_COMB : ST_END_ALL;
      ST_END_ALL:   state_nxt = ST_IDLE;
      ST_ERR:       state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
    if (i_harq_end && (state != ST_IDLE)) state_nxt = ST_ERR;
  end

  always_ff @(posedge i_mem_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      cb_num_r    <= '0;
      cb_cnt      <= '0;
      ncb_8_r     <= '0;
      rd_issued   <= '0;
      wr_pushed   <= '0;
      baddr_r     <= '0;
      addr_r      <= '0;
      ptr_r       <= 1'b0;
      comb0_rdy   <= 1'b0;
      comb1_rdy   <= 1'b0;
      ren_q       <= 1'b0;
      err_r       <= 1'b0;
      ncb_done_r  <= 1'b0;
      sto0_done_r <= 1'b0;
      sto1_done_r <= 1'b0;
    end else begin
      state <= state_nxt;
      ren_q <= ren;

      // A new done pulse wins over a same-cycle clear.
      comb0_rdy <= i_comb0_done
                   || (comb0_rdy && !i_harq_start && !((state == ST_CMD) && !ptr_r));
      comb1_rdy <= i_comb1_done
                   || (comb1_rdy && !i_harq_start && !((state == ST_CMD) && ptr_r));

      if ((state == ST_IDLE) && i_harq_start) cb_num_r <= i_cb_num;

      if (state == ST_INI) begin
        baddr_r <= i_tb_harq_baddr;
        cb_cnt  <= '0;
        ptr_r   <= 1'b0;
      end

      if (state == ST_CFG) ncb_8_r <= ncb_words(i_ncb_size);

      if (state == ST_CMD) begin
        addr_r    <= '0;
        rd_issued <= '0;
        wr_pushed <= '0;
      end else begin
        if (ren) begin
          addr_r    <= addr_r + 1'b1;
          rd_issued <= rd_issued + 1'b1;
        end
        if (wr_push) wr_pushed <= wr_pushed + 1'b1;
      end

      sto0_done_r <= do_end && !ptr_r;
      sto1_done_r <= do_end && ptr_r;
      if (do_end) begin
        ptr_r   <= !ptr_r;
        cb_cnt  <= cb_cnt + 5'd1;
        baddr_r <= baddr_r + {16'b0, ncb_8_r, 3'b0};
      end

      if (state_nxt == ST_INI) begin
        err_r      <= 1'b0;
        ncb_done_r <= 1'b0;
      end else if (state_nxt == ST_ERR) begin
        err_r      <= 1'b1;
        ncb_done_r <= 1'b1;
      end else if (state == ST_END_ALL) begin
        ncb_done_r <= 1'b1;
      end
    end
  end

  sto_ncb_rd_skid #(
    .DEPTH (SKID_DEPTH),
    .CW    (SKID_CW)
  ) u_skid (
    .i_mem_clk (i_mem_clk),
    .i_rst_n   (i_rst_n),
    .flush     (skid_flush),
    .push      (ren_q),
    .push_data (i_sto_rdata),
    .pop       (wr_push),
    .head      (skid_head),
    .count     (skid_cnt),
    .empty     (skid_empty)
  );

  assign o_sto0_done      = sto0_done_r;
  assign o_sto1_done      = sto1_done_r;
  assign o_sto_ncb_done   = ncb_done_r;
  assign o_sto_ptr        = ptr_r;
  assign o_sto_ren        = ren;
  assign o_sto_addr       = addr_r;
  assign o_wr_cmd_strb    = (state == ST_CMD);
  assign o_wr_data_number = {3'b0, ncb_8_r};
  assign o_wr_baddr       = baddr_r;
  assign o_wr             = wr_push;
  assign o_wdata          = skid_head;
  assign o_wr_termi       = err_r;
  assign o_sto_err        = err_r;

endmodule

// File: tb/tb_sto_ncb.sv
// Directed bench for sto_ncb: models the local buffer and write FIFO, records
// bus activity and checks it against hand-computed expectations.
module tb_sto_ncb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        harq_start, harq_end;
  logic [4:0]  cb_num;
  logic [14:0] ncb_size;
  logic [31:0] harq_baddr;
  logic        comb0_done, comb1_done;
  logic        sto0_done, sto1_done, sto_ncb_done, sto_ptr, sto_ren;
  logic [11:0] sto_addr;
  logic [63:0] sto_rdata;
  logic        wr_cmd_strb, wr_cmd_done;
  logic [15:0] wr_data_number;
  logic [31:0] wr_baddr;
  logic        wr;
  logic [63:0] wdata;
  logic        wfull, wr_termi, sto_err;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  sto_ncb dut (
    .i_mem_clk        (clk),
    .i_rst_n          (rst_n),
    .i_harq_start     (harq_start),
    .i_harq_end       (harq_end),
    .i_cb_num         (cb_num),
    .i_ncb_size       (ncb_size),
    .i_tb_harq_baddr  (harq_baddr),
    .i_comb0_done     (comb0_done),
    .i_comb1_done     (comb1_done),
    .o_sto0_done      (sto0_done),
    .o_sto1_done      (sto1_done),
    .o_sto_ncb_done   (sto_ncb_done),
    .o_sto_ptr        (sto_ptr),
    .o_sto_ren        (sto_ren),
    .o_sto_addr       (sto_addr),
    .i_sto_rdata      (sto_rdata),
    .o_wr_cmd_strb    (wr_cmd_strb),
    .i_wr_cmd_done    (wr_cmd_done),
    .o_wr_data_number (wr_data_number),
    .o_wr_baddr       (wr_baddr),
    .o_wr             (wr),
    .o_wdata          (wdata),
    .i_wfull          (wfull),
    .o_wr_termi       (wr_termi),
    .o_sto_err        (sto_err)
  );

  function automatic logic [63:0] pat(input logic p, input logic [11:0] a);
    return {16'hC0DE, 15'd0, p, 20'd0, a};
  endfunction

  // Recorders, sampled on the falling edge.
  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] strb_baddr_q[$];
  logic [15:0] strb_num_q[$];
  logic        strb_ptr_q[$];
  logic        done_q[$];
  logic [11:0] rd_addr_q[$];
  int  strb_cnt, wr_cnt, sto0_cnt, sto1_cnt, full_viol, err_wr;
  logic rd_pend = 1'b0;
  logic rd_p;
  logic [11:0] rd_a;
  logic rand_full = 1'b0;

  always @(negedge clk) begin
    rd_pend = sto_ren;
    rd_a    = sto_addr;
    rd_p    = sto_ptr;
    if (sto_ren) rd_addr_q.push_back(sto_addr);
    if (wr) begin
      got_q.push_back(wdata);
      wr_cnt++;
      if (wfull) full_viol++;
      if (sto_err) err_wr++;
    end
    if (wr_cmd_strb) begin
      strb_cnt++;
      strb_baddr_q.push_back(wr_baddr);
      strb_num_q.push_back(wr_data_number);
      strb_ptr_q.push_back(sto_ptr);
    end
    if (sto0_done) begin sto0_cnt++; done_q.push_back(1'b0); end
    if (sto1_done) begin sto1_cnt++; done_q.push_back(1'b1); end
  end

  // Local buffer: one-cycle read latency.
  always @(posedge clk) begin
    #1;
    if (rd_pend) sto_rdata = pat(rd_p, rd_a);
  end

  always @(posedge clk) begin
    #1;
    wfull = rand_full ? ($urandom_range(0, 1) == 1) : 1'b0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rec();
    got_q.delete(); exp_q.delete(); strb_baddr_q.delete(); strb_num_q.delete();
    strb_ptr_q.delete(); done_q.delete(); rd_addr_q.delete();
    strb_cnt = 0; wr_cnt = 0; sto0_cnt = 0; sto1_cnt = 0; full_viol = 0; err_wr = 0;
  endtask

  task automatic start_job(input logic [4:0] n, input logic [14:0] sz, input logic [31:0] ba);
    @(posedge clk); #1;
    cb_num = n; ncb_size = sz; harq_baddr = ba; harq_start = 1'b1;
    @(posedge clk); #1;
    harq_start = 1'b0;
  endtask

  task automatic pulse_comb(input logic half);
    @(posedge clk); #1;
    if (half) comb1_done = 1'b1; else comb0_done = 1'b1;
    @(posedge clk); #1;
    comb0_done = 1'b0; comb1_done = 1'b0;
  endtask

  task automatic wait_ncb_done(input string tag, input int budget);
    int n = 0;
    while (!sto_ncb_done && n < budget) begin @(posedge clk); #1; n++; end
    chk(tag, sto_ncb_done, 1'b1);
  endtask

  task automatic check_data(input string tag);
    int bad = 0;
    chk({tag, "_words"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) bad++;
    chk({tag, "_seq_errs"}, bad, 0);
  endtask

  initial begin
    int n;
    int bad;
    int wr_snap;
    rst_n = 1'b0; harq_start = 1'b0; harq_end = 1'b0; cb_num = '0; ncb_size = '0;
    harq_baddr = '0; comb0_done = 1'b0; comb1_done = 1'b0; wr_cmd_done = 1'b1;
    sto_rdata = '0; wfull = 1'b0;
    clear_rec();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ncb_done", sto_ncb_done, 1'b0);
    chk("rst_err", sto_err, 1'b0);
    chk("rst_ptr", sto_ptr, 1'b0);
    chk("rst_strb_ren_wr", {wr_cmd_strb, sto_ren, wr, wr_termi}, 4'b0);
    chk("rst_baddr", wr_baddr, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // 1 CB, Ncb=100 bytes -> 13 words
    clear_rec();
    start_job(5'd1, 15'd100, 32'h1000);
    pulse_comb(1'b0);
    wait_ncb_done("t1_done", 300);
    chk("t1_strb_cnt", strb_cnt, 1);
    chk("t1_num", strb_num_q.size() > 0 ? strb_num_q[0] : 16'hFFFF, 16'd13);
    chk("t1_baddr", strb_baddr_q.size() > 0 ? strb_baddr_q[0] : 32'hFFFF_FFFF, 32'h1000);
    bad = 0;
    for (int i = 0; i < rd_addr_q.size(); i++) if (rd_addr_q[i] != 12'(i)) bad++;
    chk("t1_rd_cnt", rd_addr_q.size(), 13);
    chk("t1_rd_addr_errs", bad, 0);
    for (int i = 0; i < 13; i++) exp_q.push_back(pat(1'b0, 12'(i)));
    check_data("t1");
    chk("t1_sto0_cnt", sto0_cnt, 1);
    chk("t1_sto1_cnt", sto1_cnt, 0);
    chk("t1_err", sto_err, 1'b0);

    // 3 CBs, Ncb=64 -> 8 words each, halves 0,1,0
    clear_rec();
    start_job(5'd3, 15'd64, 32'h1000);
    pulse_comb(1'b0);
    pulse_comb(1'b1);
    n = 0;
    while (sto0_cnt < 1 && n < 300) begin @(posedge clk); #1; n++; end
    chk("t2_first_done_seen", sto0_cnt, 1);
    pulse_comb(1'b0);
    wait_ncb_done("t2_done", 400);
    chk("t2_strb_cnt", strb_cnt, 3);
    if (strb_cnt == 3) begin
      chk("t2_baddr0", strb_baddr_q[0], 32'h1000);
      chk("t2_baddr1", strb_baddr_q[1], 32'h1040);
      chk("t2_baddr2", strb_baddr_q[2], 32'h1080);
      chk("t2_ptrs", {strb_ptr_q[0], strb_ptr_q[1], strb_ptr_q[2]}, 3'b010);
      chk("t2_num", strb_num_q[2], 16'd8);
    end
    chk("t2_done_cnt", done_q.size(), 3);
    if (done_q.size() == 3) chk("t2_done_order", {done_q[0], done_q[1], done_q[2]}, 3'b010);
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < 8; i++) exp_q.push_back(pat(c[0], 12'(i)));
    check_data("t2");

    // Random write-FIFO back-pressure
    clear_rec();
    rand_full = 1'b1;
    start_job(5'd1, 15'd100, 32'h2000);
    pulse_comb(1'b0);
    wait_ncb_done("t3_done", 1000);
    rand_full = 1'b0;
    for (int i = 0; i < 13; i++) exp_q.push_back(pat(1'b0, 12'(i)));
    check_data("t3");
    chk("t3_push_while_full", full_viol, 0);

    // comb1 arriving first must not release half 0
    clear_rec();
    start_job(5'd1, 15'd100, 32'h3000);
    pulse_comb(1'b1);
    repeat (20) @(posedge clk);
    #1;
    chk("t4_no_strb_early", strb_cnt, 0);
    chk("t4_no_done_early", sto_ncb_done, 1'b0);
    pulse_comb(1'b0);
    wait_ncb_done("t4_done", 300);
    chk("t4_strb_cnt", strb_cnt, 1);
    chk("t4_sto0_cnt", sto0_cnt, 1);

    // Abort during DATA at word 5
    clear_rec();
    start_job(5'd1, 15'd100, 32'h4000);
    pulse_comb(1'b0);
    n = 0;
    while (wr_cnt < 5 && n < 200) begin @(posedge clk); #1; n++; end
    chk("t5_reached_word5", wr_cnt >= 5, 1'b1);
    harq_end = 1'b1;
    @(posedge clk); #1;
    harq_end = 1'b0;
    chk("t5_err", sto_err, 1'b1);
    chk("t5_termi", wr_termi, 1'b1);
    chk("t5_ncb_done", sto_ncb_done, 1'b1);
    chk("t5_wr_in_err", wr, 1'b0);
    wr_snap = wr_cnt;
    repeat (12) @(posedge clk);
    #1;
    chk("t5_no_more_wr", wr_cnt, wr_snap);
    chk("t5_no_wr_while_err", err_wr, 0);
    chk("t5_no_sto0_done", sto0_cnt, 0);
    chk("t5_err_held", sto_err, 1'b1);

    // cb_num=0 is ignored: error flag must stay set (INI never entered)
    clear_rec();
    start_job(5'd0, 15'd100, 32'h5000);
    repeat (10) @(posedge clk);
    #1;
    chk("t6_cb0_err_held", sto_err, 1'b1);
    chk("t6_cb0_no_strb", strb_cnt, 0);

    // Ncb=0 -> INI clears, CFG flags error
    start_job(5'd1, 15'd0, 32'h6000);
    chk("t6_ini_err_clr", sto_err, 1'b0);
    chk("t6_ini_done_clr", sto_ncb_done, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_ncb0_err", sto_err, 1'b1);
    chk("t6_ncb0_termi", wr_termi, 1'b1);
    chk("t6_ncb0_no_strb", strb_cnt, 0);

    // Async reset mid-job
    clear_rec();
    start_job(5'd1, 15'd100, 32'h7000);
    pulse_comb(1'b0);
    n = 0;
    while (wr_cnt < 3 && n < 200) begin @(posedge clk); #1; n++; end
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_outs", {sto_ren, wr, wr_cmd_strb, sto_ptr, sto_ncb_done, sto_err}, 6'b0);
    chk("t7_rst_baddr", wr_baddr, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("t7_no_done_pulse", sto0_cnt + sto1_cnt, 0);
    chk("t7_idle_after", {sto_ncb_done, sto_ren}, 2'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
